safe_lockstep_router: RTL



---
 rtl/safe_lockstep_router.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/safe_lockstep_router.sv
// Lockstep OBI router for NHARTS cores: independent, DMR (compare) or TMR (vote) routing with drained mode switches.
// Optional feature macro: SAFE_LOCKSTEP_VOTE_EN compiles in the TMR voter and 3-way compare.
package safe_lockstep_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    localparam logic [1:0] MODE_INDEP = 2'b00;
    localparam logic [1:0] MODE_DMR   = 2'b01;
    localparam logic [1:0] MODE_TMR   = 2'b10;
endpackage

module safe_lockstep_router
    import safe_lockstep_pkg::*;
#(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MISMATCH_CNT_W  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  obi_req_t                  core_instr_req_i  [NHARTS],
    output obi_resp_t                 core_instr_resp_o [NHARTS],
    input  obi_req_t                  core_data_req_i   [NHARTS],
    output obi_resp_t                 core_data_resp_o  [NHARTS],
    output obi_req_t                  bus_instr_req_o   [NHARTS],
    input  obi_resp_t                 bus_instr_resp_i  [NHARTS],
    output obi_req_t                  bus_data_req_o    [NHARTS],
    input  obi_resp_t                 bus_data_resp_i   [NHARTS],
    input  logic                      cfg_req_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [$clog2(NHARTS)-1:0] cfg_master_i,
    output logic                      cfg_ack_o,
    output logic                      cfg_err_o,
    output logic [1:0]                mode_o,
    output logic [$clog2(NHARTS)-1:0] master_o,
    output logic                      mismatch_o,
    output logic [MISMATCH_CNT_W-1:0] mismatch_cnt_o,
    output logic                      fault_o,
    input  logic                      fault_clr_i
);
    localparam int MW = $clog2(NHARTS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
`ifdef SAFE_LOCKSTEP_VOTE_EN
    localparam bit TMR_OK = (NHARTS >= 3);
`else
    localparam bit TMR_OK = 1'b0;
`endif

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWITCH} state_t;

    state_t                    state_q;
    logic [1:0]                mode_q, pend_mode_q;
    logic [MW-1:0]             master_q, pend_master_q;
    logic                      ack_q, err_q, mismatch_q, fault_q;
    logic [MISMATCH_CNT_W-1:0] cnt_q;
    logic [CW-1:0]             out_q [2][NHARTS];
    logic [CW-1:0]             out_d [2][NHARTS];

    obi_req_t  creq  [2][NHARTS];
    obi_resp_t bresp [2][NHARTS];
    obi_req_t  breq  [2][NHARTS];
    obi_resp_t cresp [2][NHARTS];
    obi_req_t  ref_req [2];
    logic [1:0] any_req, chan_diff;

    logic [MW-1:0]     mst, sh1, sh2, src;
    logic [NHARTS-1:0] part;
    logic              locked, tmr, gate_all, drained, mism_any, inc, dec, cfg_bad;

    function automatic logic [MW-1:0] hart_at(input logic [MW-1:0] base, input int k);
        int t;
        t = (int'(base) + k) % NHARTS;
        return MW'(t);
    endfunction

    function automatic logic differs(input obi_req_t r, input obi_req_t x);
        return (r.req != x.req) || (r.addr != x.addr) || (r.we != x.we) ||
               (r.be != x.be) || ((r.we || x.we) && (r.wdata != x.wdata));
    endfunction

`ifdef SAFE_LOCKSTEP_VOTE_EN
    function automatic obi_req_t vote(input obi_req_t a, input obi_req_t b, input obi_req_t c);
        logic [$bits(obi_req_t)-1:0] va, vb, vc;
        va = a;
        vb = b;
        vc = c;
        return obi_req_t'((va & vb) | (va & vc) | (vb & vc));
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            creq[0][i]           = core_instr_req_i[i];
            creq[1][i]           = core_data_req_i[i];
            bresp[0][i]          = bus_instr_resp_i[i];
            bresp[1][i]          = bus_data_resp_i[i];
            bus_instr_req_o[i]   = breq[0][i];
            bus_data_req_o[i]    = breq[1][i];
            core_instr_resp_o[i] = cresp[0][i];
            core_data_resp_o[i]  = cresp[1][i];
        end
    end

    always_comb begin
        mst    = master_q;
        sh1    = hart_at(master_q, 1);
        sh2    = hart_at(master_q, 2);
        locked = (mode_q != MODE_INDEP);
`ifdef SAFE_LOCKSTEP_VOTE_EN
        tmr    = (mode_q == MODE_TMR);
`else
        tmr    = 1'b0;
`endif
        for (int i = 0; i < NHARTS; i++)
            part[i] = locked && ((MW'(i) == mst) || (MW'(i) == sh1) || (tmr && (MW'(i) == sh2)));
    end

    // Requests are held off outside RUN so nothing is issued under the outgoing mode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        gate_all  = (state_q != S_RUN);
        drained   = 1'b1;
        mism_any  = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        src       = '0;
        any_req   = '0;
        chan_diff = '0;
        for (int c = 0; c < 2; c++) begin
            ref_req[c]   = creq[c][mst];
            any_req[c]   = creq[c][mst].req | creq[c][sh1].req | (tmr & creq[c][sh2].req);
            chan_diff[c] = differs(ref_req[c], creq[c][sh1]);
`ifdef SAFE_LOCKSTEP_VOTE_EN
            if (tmr) begin
                ref_req[c]   = vote(creq[c][mst], creq[c][sh1], creq[c][sh2]);
                chan_diff[c] = differs(ref_req[c], creq[c][mst]) | differs(ref_req[c], creq[c][sh1]) |
                               differs(ref_req[c], creq[c][sh2]);
            end
`endif
            if (locked && any_req[c] && chan_diff[c])
                mism_any = 1'b1;

            for (int i = 0; i < NHARTS; i++) begin
                breq[c][i] = creq[c][i];
                if (part[i])
                    breq[c][i] = (MW'(i) == mst) ? ref_req[c] : '0;
                if (gate_all || (out_q[c][i] == CW'(MAX_OUTSTANDING)))
                    breq[c][i].req = 1'b0;

                inc         = breq[c][i].req && bresp[c][i].gnt;
                dec         = bresp[c][i].rvalid && (out_q[c][i] != '0);
                out_d[c][i] = out_q[c][i];
                if (inc && !dec)
                    out_d[c][i] = out_q[c][i] + CW'(1);
                else if (dec && !inc)
                    out_d[c][i] = out_q[c][i] - CW'(1);
                if (out_d[c][i] != '0)
                    drained = 1'b0;
            end

            // Participants all see the master port; gnt is masked wherever req was gated.
            for (int i = 0; i < NHARTS; i++) begin
                src             = part[i] ? mst : MW'(i);
                cresp[c][i]     = bresp[c][src];
                cresp[c][i].gnt = bresp[c][src].gnt & breq[c][src].req;
            end
        end
    end

    assign cfg_bad = (cfg_mode_i == 2'b11) || ((cfg_mode_i == MODE_TMR) && !TMR_OK) ||
                     (int'({1'b0, cfg_master_i}) >= NHARTS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_RUN;
            mode_q        <= MODE_INDEP;
            master_q      <= '0;
            pend_mode_q   <= MODE_INDEP;
            pend_master_q <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            mismatch_q    <= 1'b0;
            fault_q       <= 1'b0;
            cnt_q         <= '0;
            // NOTE: the outstanding counters gate traffic, so this small array is reset explicitly.
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < NHARTS; i++)
                    out_q[c][i] <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < NHARTS; i++)
                    out_q[c][i] <= out_d[c][i];
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (cfg_req_i)
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (drained) begin
                        state_q       <= S_SWITCH;
                        ack_q         <= 1'b1;
                        err_q         <= cfg_bad;
                        pend_mode_q   <= cfg_mode_i;
                        pend_master_q <= cfg_master_i;
                    end
                end
                S_SWITCH: begin
                    state_q <= S_RUN;
                    if (!err_q) begin
                        mode_q   <= pend_mode_q;
                        master_q <= pend_master_q;
                    end
                end
                default: state_q <= S_RUN;
            endcase

            mismatch_q <= mism_any;
            if (fault_clr_i) begin
                fault_q <= mism_any;
                cnt_q   <= mism_any ? MISMATCH_CNT_W'(1) : '0;
            end else if (mism_any) begin
                fault_q <= 1'b1;
                if (cnt_q != '1)
                    cnt_q <= cnt_q + MISMATCH_CNT_W'(1);
            end
        end
    end

    assign cfg_ack_o      = ack_q;
    assign cfg_err_o      = err_q;
    assign mode_o         = mode_q;
    assign master_o       = master_q;
    assign mismatch_o     = mismatch_q;
    assign mismatch_cnt_o = cnt_q;
    assign fault_o        = fault_q;
endmodule
